// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search controller: state encoding,
// plaintext character bounds and the printable-byte test.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        DRAIN    = 3'd2,
        CHK_ADDR = 3'd3,
        CHK_DATA = 3'd4,
        NEXT_KEY = 3'd5,
        FOUND    = 3'd6,
        FAIL     = 3'd7
    } ks_state_t;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    // Lowercase letters and space are the only bytes accepted as plaintext.
    function automatic logic is_valid_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
    endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_msg_checker.sv
// msg_checker: walks the decrypted-message RAM one byte per two cycles
// (address cycle, data cycle) and reports a single-cycle pass or fail pulse.
// Optional observation outputs are enabled by RC4_KEY_SEARCH_TAPS_EN.
module msg_checker
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chk_go,
    input  logic [7:0] msg_q,
    output logic       chk_pass,
    output logic       chk_fail,
    output logic [7:0] msg_addr
`ifdef RC4_KEY_SEARCH_TAPS_EN
    ,
    output ks_state_t  chk_state,
    output logic [7:0] idx_tap
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    ks_state_t  cstate, cstate_next;
    logic [7:0] idx, idx_next;

    // State and byte-index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cstate <= IDLE;
            idx    <= '0;
        end else begin
            cstate <= cstate_next;
            idx    <= idx_next;
        end
    end

    // Address/data loop; msg_q is valid in CHK_DATA for the address driven in CHK_ADDR.
    always_comb begin
        cstate_next = cstate;
        idx_next    = idx;
        chk_pass    = 1'b0;
        chk_fail    = 1'b0;
        msg_addr    = '0;
        case (cstate)
            IDLE: begin
                if (chk_go) begin
                    idx_next    = '0;
                    cstate_next = CHK_ADDR;
                end
            end
            CHK_ADDR: begin
                msg_addr    = idx;
                cstate_next = CHK_DATA;
            end
            CHK_DATA: begin
                if (is_valid_char(msg_q)) begin
                    if (idx == LAST_IDX) begin
                        chk_pass    = 1'b1;
                        cstate_next = IDLE;
                    end else begin
                        idx_next    = idx + 8'd1;
                        cstate_next = CHK_ADDR;
                    end
                end else begin
                    chk_fail    = 1'b1;
                    cstate_next = IDLE;
                end
            end
            default: cstate_next = IDLE;
        endcase
    end

`ifdef RC4_KEY_SEARCH_TAPS_EN
    assign chk_state = cstate;
    assign idx_tap   = idx;
`endif

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: brute-force key sequencer above the arcfour core.
// Launches the core per candidate key, waits for it to finish and return to
// idle, then has msg_checker scan the decrypted RAM for printable text.
// Defining RC4_KEY_SEARCH_TAPS_EN adds state_tap/idx_tap observation ports.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int unsigned      KEY_W   = 24,
    parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF,
    parameter int unsigned      MSG_LEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [KEY_W-1:0] key,
    output logic             start_sig,
    input  logic             arcfour_finished,
    output logic [7:0]       msg_addr,
    input  logic [7:0]       msg_q,
    output logic             busy,
    output logic             found,
    output logic             exhausted
`ifdef RC4_KEY_SEARCH_TAPS_EN
    ,
    output logic [2:0]       state_tap,
    output logic [7:0]       idx_tap
`endif
);

    ks_state_t        state, state_next;
    logic [KEY_W-1:0] key_next;
    logic             start_q;
    logic             start_edge;
    logic             chk_go, chk_pass, chk_fail;

    assign start_edge = start & ~start_q;

    // State, candidate key and start-edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            key     <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            key     <= key_next;
            start_q <= start;
        end
    end

    // Next-state and Moore outputs; CHK_ADDR covers the whole checker loop.
    always_comb begin
        state_next = state;
        key_next   = key;
        start_sig  = 1'b0;
        busy       = 1'b0;
        found      = 1'b0;
        exhausted  = 1'b0;
        chk_go     = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    key_next   = '0;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                start_sig = 1'b1;
                busy      = 1'b1;
                if (arcfour_finished) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!arcfour_finished) begin
                    chk_go     = 1'b1;
                    state_next = CHK_ADDR;
                end
            end
            CHK_ADDR: begin
                busy = 1'b1;
                if (chk_pass)      state_next = FOUND;
                else if (chk_fail) state_next = NEXT_KEY;
            end
            NEXT_KEY: begin
                busy = 1'b1;
                if (key == KEY_MAX) begin
                    state_next = FAIL;
                end else begin
                    key_next   = key + 1'b1;
                    state_next = LAUNCH;
                end
            end
            FOUND: begin
                found = 1'b1;
                if (start_edge) begin
                    key_next   = '0;
                    state_next = LAUNCH;
                end
            end
            FAIL: begin
                exhausted = 1'b1;
                if (start_edge) begin
                    key_next   = '0;
                    state_next = LAUNCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RC4_KEY_SEARCH_TAPS_EN
    ks_state_t chk_state;
`endif

    msg_checker #(
        .MSG_LEN (MSG_LEN)
    ) u_msg_checker (
        .clk       (clk),
        .reset     (reset),
        .chk_go    (chk_go),
        .msg_q     (msg_q),
        .chk_pass  (chk_pass),
        .chk_fail  (chk_fail),
        .msg_addr  (msg_addr)
`ifdef RC4_KEY_SEARCH_TAPS_EN
        ,
        .chk_state (chk_state),
        .idx_tap   (idx_tap)
`endif
    );

`ifdef RC4_KEY_SEARCH_TAPS_EN
    // The checker's own phase is reported while the top waits on it.
    assign state_tap = (state == CHK_ADDR) ? chk_state : state;
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: arcfour stub (finished 20 cycles after
// start_sig, cleared once start_sig drops) and a RAM whose contents depend
// on the current key. Expected results are queued as each search starts.
module tb_rc4_key_search_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] key;
    logic        start_sig;
    logic        fin = 1'b0;
    logic [7:0]  msg_addr;
    logic [7:0]  msg_q = 8'h00;
    logic        busy, found, exhausted;

    always #5 clk = ~clk;

    rc4_key_search_ctrl #(
        .KEY_W   (24),
        .KEY_MAX (24'd4),
        .MSG_LEN (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .key              (key),
        .start_sig        (start_sig),
        .arcfour_finished (fin),
        .msg_addr         (msg_addr),
        .msg_q            (msg_q),
        .busy             (busy),
        .found            (found),
        .exhausted        (exhausted)
    );

    // arcfour stub
    int cnt = 0;
    always @(posedge clk) begin
        if (start_sig) begin
            if (cnt == 19) fin <= 1'b1;
            else           cnt <= cnt + 1;
        end else begin
            cnt <= 0;
            fin <= 1'b0;
        end
    end

    // RAM model: keys below cfg_first_good carry cfg_bad_val at cfg_bad_idx
    logic [7:0] cfg_fill = 8'h61;
    logic [7:0] cfg_bad_val = 8'h41;
    int         cfg_first_good = 0;
    int         cfg_bad_idx = 0;
    always @(posedge clk) begin
        if (int'(key) >= cfg_first_good || int'(msg_addr) != cfg_bad_idx)
            msg_q <= cfg_fill;
        else
            msg_q <= cfg_bad_val;
    end

    typedef struct {
        logic [7:0]  fill;
        int          first_good;
        int          bad_idx;
        logic [7:0]  bad_val;
        logic        exp_found;
        logic        exp_exh;
        logic [23:0] exp_key;
        int          exp_launches;
    } vec_t;

    typedef struct {
        logic        found;
        logic        exh;
        logic [23:0] key;
        int          launches;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   launches = 0;
    logic prev_ss = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (start_sig && !prev_ss) launches++;
        prev_ss = start_sig;
    endtask

    task automatic start_search(input vec_t v, input bit push);
        exp_t e;
        cfg_fill       = v.fill;
        cfg_first_good = v.first_good;
        cfg_bad_idx    = v.bad_idx;
        cfg_bad_val    = v.bad_val;
        start = 1'b0;
        step();
        start = 1'b1;
        launches = 0;
        if (push) begin
            e.found = v.exp_found;
            e.exh = v.exp_exh;
            e.key = v.exp_key;
            e.launches = v.exp_launches;
            exp_q.push_back(e);
        end
        step();
    endtask

    task automatic await_result(input string tag);
        exp_t e;
        int   n = 0;
        while (!(found || exhausted) && n < 3000) begin
            step();
            n++;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_found"}, {31'd0, found}, {31'd0, e.found});
            check({tag, "_exh"}, {31'd0, exhausted}, {31'd0, e.exh});
            check({tag, "_key"}, {8'd0, key}, {8'd0, e.key});
            check({tag, "_busy"}, {31'd0, busy}, 32'd0);
            check({tag, "_launches"}, launches, e.launches);
        end
    endtask

    task automatic wait_fin(input logic level, input string tag);
        int n = 0;
        while (fin !== level && n < 200) begin
            step();
            n++;
        end
        check({tag, "_fin_wait"}, {31'd0, fin}, {31'd0, level});
    endtask

    initial begin
        vec_t v;
        //            fill   good bad  badval found exh key  launches
        vecs[0] = '{8'h61, 0,   0,  8'h00, 1'b1, 1'b0, 24'd0, 1};
        vecs[1] = '{8'h20, 3,   5,  8'h41, 1'b1, 1'b0, 24'd3, 4};
        vecs[2] = '{8'h61, 99,  0,  8'h00, 1'b0, 1'b1, 24'd4, 5};
        vecs[3] = '{8'h7A, 1,   31, 8'h60, 1'b1, 1'b0, 24'd1, 2};
        vecs[4] = '{8'h20, 2,   0,  8'h7B, 1'b1, 1'b0, 24'd2, 3};
        vecs[5] = '{8'h61, 99,  10, 8'h7A, 1'b1, 1'b0, 24'd0, 1};
        vecs[6] = '{8'h20, 1,   3,  8'h21, 1'b1, 1'b0, 24'd1, 2};
        vecs[7] = '{8'h61, 99,  31, 8'h7F, 1'b0, 1'b1, 24'd4, 5};

        // reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_key", {8'd0, key}, 32'd0);
        check("rst_outs", {27'd0, start_sig, busy, found, exhausted, 1'b0}, 32'd0);
        check("rst_addr", {24'd0, msg_addr}, 32'd0);

        // timing of a passing key 0
        start_search(vecs[0], 1'b1);
        check("t_busy_rise", {31'd0, busy}, 32'd1);
        check("t_ss_rise", {31'd0, start_sig}, 32'd1);
        wait_fin(1'b1, "t");
        check("t_ss_at_fin", {31'd0, start_sig}, 32'd1);
        step();
        check("t_ss_fall", {31'd0, start_sig}, 32'd0);
        wait_fin(1'b0, "t");
        for (int c = 1; c <= 64; c++) step();
        check("t_found_early", {31'd0, found}, 32'd0);
        check("t_busy_early", {31'd0, busy}, 32'd1);
        step();
        check("t_found_64", {31'd0, found}, 32'd1);
        await_result("t");

        // table of RAM patterns and expected outcomes
        for (int i = 0; i < 8; i++) begin
            start_search(vecs[i], 1'b1);
            await_result($sformatf("vec%0d", i));
        end

        // reset during the second launch
        start_search(vecs[1], 1'b0);
        begin
            int n = 0;
            while (launches < 2 && n < 500) begin
                step();
                n++;
            end
        end
        check("mr_second_launch", launches, 32'd2);
        reset = 1'b1;
        step();
        check("mr_outs", {27'd0, start_sig, busy, found, exhausted, 1'b0}, 32'd0);
        check("mr_key", {8'd0, key}, 32'd0);
        start = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        check("mr_idle", {28'd0, start_sig, busy, found, exhausted}, 32'd0);
        start_search(vecs[1], 1'b1);
        check("mr_restart_key", {8'd0, key}, 32'd0);
        check("mr_restart_ss", {31'd0, start_sig}, 32'd1);
        await_result("mr");

        // start pulse during checking is ignored; sticky FOUND; fresh start
        v = '{8'h61, 2, 20, 8'h41, 1'b1, 1'b0, 24'd2, 3};
        start_search(v, 1'b1);
        start = 1'b0;
        wait_fin(1'b1, "sb");
        wait_fin(1'b0, "sb");
        for (int c = 0; c < 6; c++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("sb_busy", {31'd0, busy}, 32'd1);
        await_result("sb");
        for (int c = 0; c < 5; c++) step();
        check("sb_sticky_found", {31'd0, found}, 32'd1);
        check("sb_sticky_key", {8'd0, key}, 32'd2);
        start_search(v, 1'b1);
        check("sb_new_key", {8'd0, key}, 32'd0);
        check("sb_new_found", {31'd0, found}, 32'd0);
        check("sb_new_busy", {31'd0, busy}, 32'd1);
        await_result("sb2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
